// File: rtl/ofifo_pkg.sv
// Shared defaults for the output FIFO bank that sits behind the sfp write port.
package ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH);

endpackage : ofifo_pkg

// File: rtl/ofifo_if.sv
// Row-level bus between sfp/readout (master) and the ofifo bank (slave).
interface ofifo_if
  import ofifo_pkg::*;
#(
  parameter int COL_N = COL,
  parameter int BW    = PSUM_BW
);

  logic [BW*COL_N-1:0] in;
  logic [COL_N-1:0]    wr;
  logic                rd;
  logic                o_full;
  logic                o_ready;
  logic                o_valid;
  logic [BW*COL_N-1:0] out;
  logic                o_overflow;

  modport master (
    output in, wr, rd,
    input  o_full, o_ready, o_valid, out, o_overflow
  );

  modport slave (
    input  in, wr, rd,
    output o_full, o_ready, o_valid, out, o_overflow
  );

endinterface : ofifo_if

// File: rtl/ofifo_fifo_col.sv
// Single-column first-word-fall-through FIFO with a sticky overflow flag.
// A write into a full column is accepted only when a pop frees the slot in
// the same cycle; otherwise the word is dropped and overflow latches.
module fifo_col
  import ofifo_pkg::*;
#(
  parameter int BW    = PSUM_BW,
  parameter int DEPTH = OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] din,
  input  logic          wr,
  input  logic          pop,
  output logic [BW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wr_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign overflow = overflow_q;
  assign dout     = mem[rptr_q];
  assign wr_en    = wr & (~full | pop);

  // Next pointers, occupancy and sticky overflow.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wptr_d = wptr_q + PTR_W'(1);
    if (pop)   rptr_d = rptr_q + PTR_W'(1);
    count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    if (wr & full & ~pop) overflow_d = 1'b1;
  end

  // Control state register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
    if (wr_en) mem[wptr_q] <= din;
  end

endmodule : fifo_col

// File: rtl/ofifo.sv
// Output FIFO bank: one fifo_col per column, rows presented only when every
// column holds data, and one read pops all columns together.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic   clk,
  input  logic   reset,
  ofifo_if.slave bus
);

  logic [col-1:0] empty;
  logic [col-1:0] full;
  logic [col-1:0] ovf;
  logic           pop;

  // A read with any column empty is ignored entirely.
  assign pop            = bus.rd & bus.o_valid;
  assign bus.o_valid    = ~|empty;
  assign bus.o_full     = |full;
  assign bus.o_ready    = ~bus.o_full;
  assign bus.o_overflow = |ovf;

  for (genvar k = 0; k < col; k++) begin : g_col
    fifo_col #(
      .BW    (psum_bw),
      .DEPTH (depth)
    ) u_col (
      .clk      (clk),
      .reset    (reset),
      .din      (bus.in[k*psum_bw +: psum_bw]),
      .wr       (bus.wr[k]),
      .pop      (pop),
      .dout     (bus.out[k*psum_bw +: psum_bw]),
      .empty    (empty[k]),
      .full     (full[k]),
      .overflow (ovf[k])
    );
  end

endmodule : ofifo

// File: tb/tb_ofifo.sv
// Directed bench for ofifo: idle reads, staggered fill, full/wrap, write+pop
// at full, overflow stickiness and asynchronous mid-stream reset.
module tb_ofifo;
  import ofifo_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  ofifo_if bus ();

  ofifo u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] row(input logic [15:0] v);
    return {8{v}};
  endfunction

  logic [127:0] stag;

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    reset    = 1'b1;
    bus.in   = '0;
    bus.wr   = '0;
    bus.rd   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Idle after reset
    check("rst_valid", 128'(bus.o_valid), 128'(0));
    check("rst_full", 128'(bus.o_full), 128'(0));
    check("rst_ready", 128'(bus.o_ready), 128'(1));
    check("rst_ovf", 128'(bus.o_overflow), 128'(0));

    // Reads while empty are ignored
    bus.rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_rd_valid", 128'(bus.o_valid), 128'(0));
      check("idle_rd_ovf", 128'(bus.o_overflow), 128'(0));
    end
    bus.rd = 1'b0;

    // Staggered fill: column k written at cycle k with 0x0100+k
    stag = '0;
    for (int k = 0; k < 8; k++) begin
      bus.wr = 8'(1 << k);
      bus.in = row(16'h0100 + 16'(k));
      stag[k*16 +: 16] = 16'h0100 + 16'(k);
      tick();
      check("stag_valid", 128'(bus.o_valid), 128'(k == 7));
    end
    bus.wr = '0;
    check("stag_out", bus.out, stag);
    check("stag_out_top", 128'(bus.out[127:112]), 128'(16'h0107));
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("stag_pop_valid", 128'(bus.o_valid), 128'(0));

    // Fill all columns to depth with index values
    for (int i = 0; i < 64; i++) begin
      bus.wr = 8'hFF;
      bus.in = row(16'(i));
      tick();
      check("fill_full", 128'(bus.o_full), 128'(i == 63));
    end
    check("fill_ready", 128'(bus.o_ready), 128'(0));
    check("fill_head", bus.out, row(16'h0000));

    // Simultaneous write and pop at full: no loss, no overflow
    bus.wr = 8'hFF;
    bus.in = row(16'hABCD);
    bus.rd = 1'b1;
    tick();
    bus.wr = '0;
    bus.rd = 1'b0;
    check("wp_full", 128'(bus.o_full), 128'(1));
    check("wp_ovf", 128'(bus.o_overflow), 128'(0));
    check("wp_head", bus.out, row(16'h0001));

    // Overflow on column 3 at full
    bus.wr = 8'h08;
    bus.in = row(16'hEEEE);
    tick();
    bus.wr = '0;
    check("ovf_flag", 128'(bus.o_overflow), 128'(1));
    check("ovf_full", 128'(bus.o_full), 128'(1));
    check("ovf_head", bus.out, row(16'h0001));

    // Drain: 1..63 then ABCD; pointers wrap through 0
    for (int i = 1; i <= 64; i++) begin
      check("drain_out", bus.out, (i == 64) ? row(16'hABCD) : row(16'(i)));
      check("drain_valid", 128'(bus.o_valid), 128'(1));
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
    end
    check("drain_empty", 128'(bus.o_valid), 128'(0));
    check("drain_notfull", 128'(bus.o_full), 128'(0));
    check("ovf_sticky", 128'(bus.o_overflow), 128'(1));

    // Reset mid-stream with 5 rows queued
    for (int i = 0; i < 5; i++) begin
      bus.wr = 8'hFF;
      bus.in = row(16'h5000 + 16'(i));
      tick();
    end
    bus.wr = '0;
    check("pre_rst_valid", 128'(bus.o_valid), 128'(1));
    check("pre_rst_head", bus.out, row(16'h5000));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 128'(bus.o_valid), 128'(0));
    check("async_rst_ovf", 128'(bus.o_overflow), 128'(0));
    check("async_rst_ready", 128'(bus.o_ready), 128'(1));
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_valid", 128'(bus.o_valid), 128'(0));

    // Behaves empty after reset
    bus.wr = 8'hFF;
    bus.in = row(16'h7777);
    tick();
    bus.wr = '0;
    check("post_rst_wvalid", 128'(bus.o_valid), 128'(1));
    check("post_rst_out", bus.out, row(16'h7777));
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("post_rst_pop", 128'(bus.o_valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_ofifo
